// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle shared by the pipeline WB stage, the
// long-latency unit and the write-port arbiter.
interface wb_port_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
);
  logic                    pipe_we_WB;
  logic [ADDR_WIDTH-1:0]   pipe_rd_WB;
  logic [DATA_WIDTH-1:0]   pipe_wdata_WB;
  logic                    lu_valid;
  logic                    lu_ready;
  logic [ADDR_WIDTH-1:0]   lu_rd;
  logic [DATA_WIDTH-1:0]   lu_wdata;
  logic                    rf_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    stall_req;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output pipe_we_WB, pipe_rd_WB, pipe_wdata_WB, lu_valid, lu_rd, lu_wdata,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
  );

  modport slave (
    input  pipe_we_WB, pipe_rd_WB, pipe_wdata_WB, lu_valid, lu_rd, lu_wdata,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage (always wins) and buffered/bypassed long-latency unit results.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  wb_port_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);
  localparam logic [STV_W-1:0] STV_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic [STV_W-1:0] starve, starve_inc;
  logic [1:0]       state;

  logic pipe_busy, fifo_empty, lu_ready, lu_fire;
  logic push, pop, bypass;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  assign pipe_busy  = bus.pipe_we_WB && (bus.pipe_rd_WB != '0);
  assign fifo_empty = (count == '0);
  // Depends only on the registered count, never on a same-cycle pop.
  assign lu_ready   = (count < DEPTH_C) && !rst;
  assign lu_fire    = bus.lu_valid && lu_ready;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (pipe_busy) begin
      rf_we    = 1'b1;
      rf_waddr = bus.pipe_rd_WB;
      rf_wdata = bus.pipe_wdata_WB;
    end else if (!fifo_empty) begin
      rf_we    = 1'b1;
      {rf_waddr, rf_wdata} = mem[rd_ptr];
      pop      = 1'b1;
    end else if (lu_fire && (bus.lu_rd != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = bus.lu_rd;
      rf_wdata = bus.lu_wdata;
      bypass   = 1'b1;
    end
  end

  // Accepted results to x0 are dropped: neither bypassed nor enqueued.
  assign push = lu_fire && (bus.lu_rd != '0) && !bypass;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.lu_rd, bus.lu_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  assign starve_inc = (starve == STV_MAX) ? starve : starve + STV_W'(1);

  // Transitions look at count_next so stall_req drops the cycle after the
  // emptying pop and rises the cycle after the counter hits the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      starve <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          starve <= '0;
          if (count_next != '0) state <= S_WAIT;
        end
        S_WAIT: begin
          if (count_next == '0) begin
            state  <= S_IDLE;
            starve <= '0;
          end else if (pop || fifo_empty) begin
            starve <= '0;
          end else if (starve_inc == LIMIT_C) begin
            state  <= S_STALL;
            starve <= '0;
          end else begin
            starve <= starve_inc;
          end
        end
        S_STALL: begin
          starve <= '0;
          if (count_next == '0) state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          starve <= '0;
        end
      endcase
    end
  end

  assign bus.lu_ready   = lu_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.stall_req  = (state == S_STALL);
  assign bus.fifo_count = count;
endmodule
